aud_recorder: RTL and testbench

- Captures left-channel 16-bit I2S samples from the WM8731 ADC and emits one SRAM write request per sample at sequential word addresses.
- Sits directly upstream of the SRAM write path inside the recorder top; the codec bit clock is its clock.
- Controlled by debounced one-cycle key strobes (start/resume, pause, stop).

---
 rtl/aud_recorder_pkg.sv | 25 ++
 rtl/aud_recorder_if.sv | 34 +++
 rtl/aud_recorder_deser.sv | 57 +++++
 rtl/aud_recorder.sv | 120 ++++++++++++
 tb/tb_aud_recorder.sv | 229 ++++++++++++++++++++++
 5 files changed

// File: rtl/aud_recorder_pkg.sv
// aud_pkg: shared audio-path widths and the recorder state encoding.
// Used by the recorder, player and DSP blocks.
package aud_pkg;

  localparam int unsigned AUD_DATA_W = 16;
  localparam int unsigned AUD_ADDR_W = 20;

  // Raw encodings kept as constants so older code can compare against them
  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_ARMED  = 3'd1;
  localparam logic [2:0] ST_SHIFT  = 3'd2;
  localparam logic [2:0] ST_WRITE  = 3'd3;
  localparam logic [2:0] ST_PAUSED = 3'd4;
  localparam logic [2:0] ST_FULL   = 3'd5;

  typedef enum logic [2:0] {
    IDLE   = ST_IDLE,
    ARMED  = ST_ARMED,
    SHIFT  = ST_SHIFT,
    WRITE  = ST_WRITE,
    PAUSED = ST_PAUSED,
    FULL   = ST_FULL
  } rec_state_t;

endpackage

// File: rtl/aud_recorder_if.sv
// aud_recorder_if: codec serial inputs, key strobes and SRAM write request.
//   master: drives i_lrc/i_data/i_start/i_pause/i_stop, receives o_*.
//   slave : the recorder; receives i_*, drives o_address/o_data/o_we,
//           o_last_addr, o_busy, o_full.
interface aud_recorder_if
  import aud_pkg::*;
#(
  parameter int unsigned DATA_W = AUD_DATA_W,
  parameter int unsigned ADDR_W = AUD_ADDR_W
);

  logic              i_lrc;
  logic              i_data;
  logic              i_start;
  logic              i_pause;
  logic              i_stop;
  logic [ADDR_W-1:0] o_address;
  logic [DATA_W-1:0] o_data;
  logic              o_we;
  logic [ADDR_W-1:0] o_last_addr;
  logic              o_busy;
  logic              o_full;

  modport master (
    output i_lrc, i_data, i_start, i_pause, i_stop,
    input  o_address, o_data, o_we, o_last_addr, o_busy, o_full
  );

  modport slave (
    input  i_lrc, i_data, i_start, i_pause, i_stop,
    output o_address, o_data, o_we, o_last_addr, o_busy, o_full
  );

endinterface

// File: rtl/aud_recorder_deser.sv
// i2s_left_deser: LR-clock falling-edge detect plus MSB-first sample shifter.
//   i_clk, i_rst : bit clock, async active-high reset
//   lrc_i        : ADC LR clock (low = left)
//   data_i       : serial data bit
//   en_i         : shift enable; low clears the bit counter
//   fall_c_o     : LR clock fell on this edge (left slot starts)
//   valid_c_o    : this edge carries the last bit of the sample
//   sample_c_o   : complete sample, valid with valid_c_o
module i2s_left_deser
  import aud_pkg::*;
#(
  parameter int unsigned DATA_W = AUD_DATA_W
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              lrc_i,
  input  logic              data_i,
  input  logic              en_i,
  output logic              fall_c_o,
  output logic              valid_c_o,
  output logic [DATA_W-1:0] sample_c_o
);

  localparam int unsigned CNT_W = $clog2(DATA_W);

  logic              lrc_q;
  logic [CNT_W-1:0]  bitcnt_q, bitcnt_d;
  // Holds the first DATA_W-1 bits; the last bit is appended combinationally
  logic [DATA_W-2:0] shift_q, shift_d;

  // Shift/count while enabled, otherwise restart the counter
  always_comb begin
    bitcnt_d = '0;
    shift_d  = shift_q;
    if (en_i) begin
      shift_d  = {shift_q[DATA_W-3:0], data_i};
      bitcnt_d = bitcnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      lrc_q    <= 1'b0;
      bitcnt_q <= '0;
      shift_q  <= '0;
    end else begin
      lrc_q    <= lrc_i;
      bitcnt_q <= bitcnt_d;
      shift_q  <= shift_d;
    end
  end

  assign fall_c_o   = lrc_q & ~lrc_i;
  assign valid_c_o  = en_i && (bitcnt_q == CNT_W'(DATA_W - 1));
  assign sample_c_o = {shift_q, data_i};

endmodule

// File: rtl/aud_recorder.sv
// aud_recorder: records left-channel I2S samples as sequential SRAM writes.
//   i_clk, i_rst : codec bit clock, async active-high reset
//   bus (slave)  : serial inputs, start/pause/stop strobes, write request,
//                  last written address, busy and full status
module aud_recorder
  import aud_pkg::*;
#(
  parameter int unsigned       DATA_W   = AUD_DATA_W,
  parameter int unsigned       ADDR_W   = AUD_ADDR_W,
  parameter logic [ADDR_W-1:0] MAX_ADDR = {ADDR_W{1'b1}}
) (
  input  logic           i_clk,
  input  logic           i_rst,
  aud_recorder_if.slave  bus
);

  rec_state_t        state_q, state_d;
  logic [ADDR_W-1:0] address_q, address_d;
  logic [ADDR_W-1:0] last_addr_q, last_addr_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              we_q, we_d;
  logic              busy_q, busy_d;
  logic              full_q, full_d;

  logic              fall_c;
  logic              valid_c;
  logic [DATA_W-1:0] sample_c;

  i2s_left_deser #(.DATA_W(DATA_W)) u_deser (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .lrc_i      (bus.i_lrc),
    .data_i     (bus.i_data),
    .en_i       (state_q == SHIFT),
    .fall_c_o   (fall_c),
    .valid_c_o  (valid_c),
    .sample_c_o (sample_c)
  );

  // Next state and outputs; stop beats pause beats start
  always_comb begin
    state_d     = state_q;
    address_d   = address_q;
    last_addr_d = last_addr_q;
    data_d      = data_q;
    we_d        = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.i_start) begin
          address_d = '0;
          state_d   = ARMED;
        end
      end
      ARMED: begin
        if (bus.i_stop)       state_d = IDLE;
        else if (bus.i_pause) state_d = PAUSED;
        else if (fall_c)      state_d = SHIFT;
      end
      SHIFT: begin
        if (bus.i_stop)       state_d = IDLE;
        else if (bus.i_pause) state_d = PAUSED;
        else if (valid_c) begin
          data_d  = sample_c;
          we_d    = 1'b1;
          state_d = WRITE;
        end
      end
      WRITE: begin
        // The strobe already fired; a stop or pause here only follows it
        last_addr_d = address_q;
        if (bus.i_stop) begin
          state_d = IDLE;
        end else if (address_q == MAX_ADDR) begin
          state_d = FULL;
        end else begin
          address_d = address_q + ADDR_W'(1);
          state_d   = bus.i_pause ? PAUSED : ARMED;
        end
      end
      PAUSED: begin
        if (bus.i_stop)       state_d = IDLE;
        else if (bus.i_start) state_d = ARMED;
      end
      FULL: begin
        if (bus.i_stop) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d == ARMED) || (state_d == SHIFT) || (state_d == WRITE);
    full_d = (state_d == FULL);
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q     <= IDLE;
      address_q   <= '0;
      last_addr_q <= '0;
      data_q      <= '0;
      we_q        <= 1'b0;
      busy_q      <= 1'b0;
      full_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      address_q   <= address_d;
      last_addr_q <= last_addr_d;
      data_q      <= data_d;
      we_q        <= we_d;
      busy_q      <= busy_d;
      full_q      <= full_d;
    end
  end

  assign bus.o_address   = address_q;
  assign bus.o_data      = data_q;
  assign bus.o_we        = we_q;
  assign bus.o_last_addr = last_addr_q;
  assign bus.o_busy      = busy_q;
  assign bus.o_full      = full_q;

endmodule

// File: tb/tb_aud_recorder.sv
// Scoreboard bench for aud_recorder: frame-level model of the recording
// session predicts every SRAM write; a monitor pops and compares on o_we.
module tb_aud_recorder;

  localparam logic [19:0] MAX = 20'd4;
  localparam int EV_NONE = 0, EV_START = 1, EV_PAUSE = 2, EV_STOP = 3, EV_STOPSTART = 4;

  typedef struct {
    logic [19:0] addr;
    logic [15:0] data;
    bit          chk_next;
  } wr_t;

  typedef enum {M_OFF, M_REC, M_PAUSED, M_FULL} mode_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  aud_recorder_if bus ();

  aud_recorder #(.MAX_ADDR(MAX)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  wr_t         exp_q[$];
  int          checks = 0;
  int          errors = 0;
  mode_t       m_mode;
  logic [19:0] m_addr;
  logic [19:0] m_last;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Session-level effect of a key strobe
  function automatic void apply_event(input int ev);
    case (ev)
      EV_START: begin
        if (m_mode == M_OFF) begin
          m_mode = M_REC;
          m_addr = 20'd0;
        end else if (m_mode == M_PAUSED) begin
          m_mode = M_REC;
        end
      end
      EV_PAUSE: if (m_mode == M_REC) m_mode = M_PAUSED;
      EV_STOP, EV_STOPSTART: m_mode = M_OFF;
      default: ;
    endcase
  endfunction

  task automatic set_strobes(input int ev);
    bus.i_start = (ev == EV_START) || (ev == EV_STOPSTART);
    bus.i_pause = (ev == EV_PAUSE);
    bus.i_stop  = (ev == EV_STOP) || (ev == EV_STOPSTART);
  endtask

  task automatic boundary_check();
    check("busy", 32'(bus.o_busy), 32'(m_mode == M_REC));
    check("full", 32'(bus.o_full), 32'(m_mode == M_FULL));
    check("last_addr", 32'(bus.o_last_addr), 32'(m_last));
    check("we_quiet", 32'(bus.o_we), 32'd0);
    if (m_mode != M_OFF) check("address", 32'(bus.o_address), 32'(m_addr));
  endtask

  // Strobe between frames (LR clock held high, no falling edge)
  task automatic strobe(input int ev);
    @(negedge clk);
    bus.i_lrc  = 1'b1;
    bus.i_data = 1'b0;
    set_strobes(ev);
    apply_event(ev);
    @(negedge clk);
    set_strobes(EV_NONE);
    boundary_check();
  endtask

  // One 64-cycle frame; ev fires at slot cycle ev_j (0 = LR falling edge)
  task automatic frame(input logic [15:0] left, input logic [15:0] right,
                       input int ev, input int ev_j);
    bit cancel;
    cancel = (ev == EV_PAUSE || ev == EV_STOP || ev == EV_STOPSTART) && (ev_j <= 16);
    if (m_mode == M_REC && !cancel) begin
      exp_q.push_back('{m_addr, left,
                        !((ev == EV_STOP || ev == EV_STOPSTART) && ev_j == 17)});
      m_last = m_addr;
      if (m_addr == MAX) m_mode = M_FULL;
      else m_addr = m_addr + 20'd1;
    end
    apply_event(ev);
    for (int j = 0; j < 64; j++) begin
      @(negedge clk);
      bus.i_lrc = (j >= 32);
      if (j >= 1 && j <= 16)       bus.i_data = left[16-j];
      else if (j >= 33 && j <= 48) bus.i_data = right[48-j];
      else                         bus.i_data = 1'($urandom_range(0, 1));
      set_strobes((j == ev_j) ? ev : EV_NONE);
    end
    @(negedge clk);
    bus.i_lrc = 1'b1;
    set_strobes(EV_NONE);
    boundary_check();
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_address"}, 32'(bus.o_address), 32'd0);
    check({tag, "_data"}, 32'(bus.o_data), 32'd0);
    check({tag, "_we"}, 32'(bus.o_we), 32'd0);
    check({tag, "_last"}, 32'(bus.o_last_addr), 32'd0);
    check({tag, "_busy"}, 32'(bus.o_busy), 32'd0);
    check({tag, "_full"}, 32'(bus.o_full), 32'd0);
  endtask

  // Reset pulse in the middle of bit 10 of a recording frame
  task automatic frame_with_reset(input logic [15:0] left);
    for (int j = 0; j < 64; j++) begin
      @(negedge clk);
      bus.i_lrc = (j >= 32);
      bus.i_data = (j >= 1 && j <= 16) ? left[16-j] : 1'b0;
      if (j == 10) begin
        #2 rst = 1'b1;
        #1 check_all_zero("mid_reset");
      end
      if (j == 12) rst = 1'b0;
    end
    m_mode = M_OFF;
    m_addr = 20'd0;
    m_last = 20'd0;
    @(negedge clk);
    bus.i_lrc = 1'b1;
    boundary_check();
  endtask

  // Monitor: every o_we must match the oldest predicted write
  bit  pend = 1'b0;
  wr_t pend_wr;
  always @(negedge clk) begin
    if (rst) begin
      pend = 1'b0;
    end else begin
      if (pend) begin
        check("we_one_cycle", 32'(bus.o_we), 32'd0);
        check("last_after_write", 32'(bus.o_last_addr), 32'(pend_wr.addr));
        if (pend_wr.chk_next)
          check("addr_after_write", 32'(bus.o_address),
                32'((pend_wr.addr == MAX) ? pend_wr.addr : pend_wr.addr + 20'd1));
        pend = 1'b0;
      end
      if (bus.o_we && !pend) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_write addr=%0h data=%0h at %0t",
                   bus.o_address, bus.o_data, $time);
        end else begin
          pend_wr = exp_q.pop_front();
          check("write_addr", 32'(bus.o_address), 32'(pend_wr.addr));
          check("write_data", 32'(bus.o_data), 32'(pend_wr.data));
          pend = 1'b1;
        end
      end
    end
  end

  initial begin
    int ev, r;
    rst = 1'b1;
    bus.i_lrc = 1'b1;
    bus.i_data = 1'b0;
    set_strobes(EV_NONE);
    m_mode = M_OFF;
    m_addr = 20'd0;
    m_last = 20'd0;
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    rst = 1'b0;

    strobe(EV_START);
    frame(16'hA5C3, 16'h1234, EV_NONE, 0);
    strobe(EV_STOP);
    strobe(EV_START);
    frame(16'h0001, 16'h1234, EV_NONE, 0);
    frame(16'h8000, 16'h1234, EV_NONE, 0);
    frame(16'hFFFF, 16'h1234, EV_NONE, 0);
    frame(16'hAAAA, 16'h1234, EV_PAUSE, 7);
    strobe(EV_START);
    frame(16'h5555, 16'h1234, EV_NONE, 0);
    frame(16'h1111, 16'h1234, EV_NONE, 0);
    frame(16'h2222, 16'h1234, EV_NONE, 0);
    strobe(EV_STOP);
    strobe(EV_START);
    frame(16'h3333, 16'h1234, EV_STOPSTART, 5);
    strobe(EV_START);
    frame(16'h4444, 16'h1234, EV_NONE, 0);
    frame_with_reset(16'hBEEF);
    frame(16'h6666, 16'h1234, EV_NONE, 0);
    strobe(EV_START);
    frame(16'h7777, 16'h1234, EV_NONE, 0);
    frame(16'h8888, 16'h1234, EV_PAUSE, 17);
    strobe(EV_START);
    frame(16'h9999, 16'h1234, EV_STOP, 17);
    frame(16'hCCCC, 16'h1234, EV_START, 0);
    frame(16'hDDDD, 16'h1234, EV_NONE, 0);

    for (int n = 0; n < 80; n++) begin
      r = int'($urandom_range(0, 9));
      if (r <= 4)      ev = EV_NONE;
      else if (r <= 6) ev = EV_START;
      else if (r == 7) ev = EV_PAUSE;
      else if (r == 8) ev = EV_STOP;
      else             ev = (m_mode == M_OFF) ? EV_NONE : EV_STOPSTART;
      frame(16'($urandom), 16'($urandom), ev, int'($urandom_range(0, 63)));
    end

    repeat (3) @(negedge clk);
    check("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
